// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the PWM channel scheduler and its period counter.
package pwm_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} pwm_state_e;
    typedef logic [WIDTH_DEF-1:0] count_t;
endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: prescaled free-running period counter with wrap flag.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_count;
    logic             w_tick;
    assign w_tick  = (r_pre == PW'(PRESCALE - 1));
    assign o_wrap  = i_run && w_tick && (r_count == '1);
    assign o_count = r_count;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (i_run) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/pwm_channel_scheduler.sv
// pwm_channel_scheduler: shared-counter PWM outputs with shadowed duty updates
// applied only at the period boundary, plus a period-preserving run/stop FSM.
module pwm_channel_scheduler
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = 1
) (
    input  logic                        Scheduler_Clock,
    input  logic                        Scheduler_Reset,
    input  logic                        Enable,
    input  logic                        Upd_Valid,
    output logic                        Upd_Ready,
    input  logic [$clog2(CHANNELS)-1:0] Upd_Channel,
    input  logic [WIDTH-1:0]            Upd_Duty,
    output logic [CHANNELS-1:0]         Pwm_Out,
    output logic                        Period_Start,
    output logic                        Busy,
    output logic [WIDTH-1:0]            Count_Out
);
    pwm_state_e          r_state, w_next;
    logic [WIDTH-1:0]    r_active [CHANNELS];
    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    logic [CHANNELS-1:0] r_pending, r_pwm;
    logic                r_period_start, w_wrap, w_in_range, w_accept;
    logic [WIDTH-1:0]    w_count;

    pwm_period_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) u_counter (
        .i_clk   (Scheduler_Clock),
        .i_rst_n (Scheduler_Reset),
        .i_run   (r_state != IDLE),
        .i_clear (w_next == IDLE),
        .o_count (w_count),
        .o_wrap  (w_wrap)
    );

    // Out-of-range channels always handshake; their data is dropped below.
    assign w_in_range   = int'(Upd_Channel) < CHANNELS;
    assign Upd_Ready    = !(w_in_range && r_pending[Upd_Channel]);
    assign w_accept     = Upd_Valid && Upd_Ready;
    assign Busy         = r_state != IDLE;
    assign Pwm_Out      = r_pwm;
    assign Period_Start = r_period_start;
    assign Count_Out    = w_count;

    // RUN and STOPPING differ only in Enable, so both only leave at a wrap.
    always_comb begin
        w_next = r_state;
        w_next = Enable ? RUN : ((r_state == IDLE || w_wrap) ? IDLE : STOPPING);
    end

    always_ff @(posedge Scheduler_Clock or negedge Scheduler_Reset) begin
        if (!Scheduler_Reset) r_state <= IDLE;
        else                  r_state <= w_next;
    end

    always_ff @(posedge Scheduler_Clock or negedge Scheduler_Reset) begin
        if (!Scheduler_Reset) begin
            r_pending      <= '0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_active[i] <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_period_start <= (r_state == IDLE && Enable) || (w_wrap && w_next == RUN);
            for (int i = 0; i < CHANNELS; i++) begin
                r_pwm[i] <= (r_state != IDLE) && (w_count < r_active[i]);
                if (w_wrap && r_pending[i]) begin
                    r_active[i]  <= r_shadow[i];
                    r_pending[i] <= 1'b0;
                end
                // A write landing on the wrap cycle re-arms pending for the next wrap.
                if (w_accept && w_in_range && int'(Upd_Channel) == i) begin
                    if (r_state == IDLE) r_active[i] <= Upd_Duty;
                    else begin
                        r_shadow[i]  <= Upd_Duty;
                        r_pending[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
